// File: rtl/ex_div_seq.sv
// ex_div_seq
// Iterative 32-bit restoring divider for the EX stage (DIV / DIVU).
// An operation accepted in IDLE runs 32 shift/subtract iterations in BUSY.
// The result is then presented for exactly one cycle in DONE (or in ZERO for
// a zero divisor). While the divide is pending, the block holds the pipeline
// through stallreq_for_ex.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              synchronous active-high reset
//   div_start        EX holds a DIV/DIVU (level, stable while stalled)
//   div_signed       1 = DIV (two's complement), 0 = DIVU
//   dividend         rs operand (32 bits)
//   divisor          rt operand (32 bits)
//   annul            cancels any in-flight operation
//   stallreq_for_ex  freeze request to the stall controller
//   div_ready        one-cycle result-valid pulse
//   div_hi           remainder (zero outside DONE)
//   div_lo           quotient (zero outside DONE)

module ex_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        stallreq_for_ex,
  output logic        div_ready,
  output logic [31:0] div_hi,
  output logic [31:0] div_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs_mag;
  logic        qneg;
  logic        rneg;

  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [31:0] rem_shift;
  logic        rem_carry;
  logic [32:0] trial;
  logic        accept;

  // Operand magnitudes. In signed mode, a negative operand is negated. For
  // 0x80000000 the negation wraps back to itself, which is the correct
  // unsigned magnitude.
  always_comb begin
    dvd_abs = dividend;
    dvs_abs = divisor;
    if (div_signed && dividend[31]) dvd_abs = ~dividend + 32'd1;
    if (div_signed && divisor[31])  dvs_abs = ~divisor + 32'd1;
  end

  // One restoring step on the {rem, quo} pair shifted left by one.
  // The bit shifted out of rem is kept as bit 32 of the subtraction.
  // Without it, a remainder at or above 2^31 would be truncated when the
  // divisor is very large.
  always_comb begin
    rem_carry = rem[31];
    rem_shift = {rem[30:0], quo[31]};
    trial     = {rem_carry, rem_shift} - {1'b0, dvs_mag};
    accept    = ~trial[32];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. annul overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (div_start) begin
          if (divisor == 32'd0) state_nxt = ZERO;
          else                  state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 6'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  // Datapath. Operands and sign flags are captured only when IDLE moves to
  // BUSY. Changes to the inputs while BUSY are ignored.
  always_ff @(posedge clk) begin
    if (rst || annul) begin
      cnt     <= 6'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      dvs_mag <= 32'd0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start && (divisor != 32'd0)) begin
            cnt     <= 6'd0;
            rem     <= 32'd0;
            quo     <= dvd_abs;
            dvs_mag <= dvs_abs;
            qneg    <= div_signed & (dividend[31] ^ divisor[31]);
            rneg    <= div_signed & dividend[31];
          end
        end
        BUSY: begin
          rem <= accept ? trial[31:0] : rem_shift;
          quo <= {quo[30:0], accept};
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // The stall request covers the accepting IDLE cycle and all of BUSY. It
  // drops in DONE/ZERO so that the pipeline advances on the div_ready cycle.
  always_comb begin
    stallreq_for_ex = ((state == IDLE) && div_start && !annul) || (state == BUSY);
  end

  // Result outputs depend only on registered state and are zero outside
  // DONE. ZERO gives hi = lo = 0.
  always_comb begin
    div_ready = (state == DONE) || (state == ZERO);
    div_lo    = 32'd0;
    div_hi    = 32'd0;
    if (state == DONE) begin
      div_lo = qneg ? (~quo + 32'd1) : quo;
      div_hi = rneg ? (~rem + 32'd1) : rem;
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// tb_ex_div_seq
// Directed, table-driven bench for ex_div_seq. Inputs are driven and outputs
// are sampled just after the falling clock edge. Cycle t is the cycle in
// which div_start is first seen in IDLE.

module tb_ex_div_seq;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stallreq_for_ex;
  logic        div_ready;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  int nVectors;
  int nMiscompares;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  ex_div_seq dut (
    .clk             (clk),
    .rst             (rst),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .dividend        (dividend),
    .divisor         (divisor),
    .annul           (annul),
    .stallreq_for_ex (stallreq_for_ex),
    .div_ready       (div_ready),
    .div_hi          (div_hi),
    .div_lo          (div_lo)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an operation in cycle t and leave div_start high.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    #1;
  endtask

  // Wait, with a bound, for div_ready. lat is counted in cycles after the
  // call point. stalls counts the cycles after the call point in which
  // stallreq_for_ex was high.
  task automatic waitResult(output int lat, output int stalls,
                            output logic [31:0] hi, output logic [31:0] lo);
    lat    = -1;
    stalls = 0;
    hi     = 32'hDEADBEEF;
    lo     = 32'hDEADBEEF;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (stallreq_for_ex) stalls++;
      if (div_ready) begin
        lat = c;
        hi  = div_hi;
        lo  = div_lo;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          stalls;
    int          cnt;
    logic [31:0] hi;
    logic [31:0] lo;

    nVectors     = 0;
    nMiscompares = 0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF, 32'h0000000F, 33};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001, 32'h00000001, 33};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
    vecs[6] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'h00000002, 32'hFFFFFFFE, 33};
    vecs[7] = '{1'b0, 32'h80000000,   32'h00000002,   32'h40000000, 32'h00000000, 33};
    vecs[8] = '{1'b0, 32'd50,         32'd5,          32'd10,       32'd0,        33};
    vecs[9] = '{1'b1, 32'h12345678,   32'h00000000,   32'h00000000, 32'h00000000, 1};

    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    annul      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_ready", {31'd0, div_ready}, 32'd0);
    checkOutput("reset_stall", {31'd0, stallreq_for_ex}, 32'd0);
    checkOutput("reset_hi", div_hi, 32'd0);
    checkOutput("reset_lo", div_lo, 32'd0);

    // Table: latency, stall length, quotient, remainder, single-cycle ready.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
      cnt = stallreq_for_ex ? 1 : 0;
      waitResult(lat, stalls, hi, lo);
      div_start = 1'b0;
      checkOutput($sformatf("v%0d_lat", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_stall", i), cnt + stalls, vecs[i].expLat);
      checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].expLo);
      checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].expHi);
      checkOutput($sformatf("v%0d_readyoff", i), {31'd0, stallreq_for_ex}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput($sformatf("v%0d_pulse", i), {31'd0, div_ready}, 32'd0);
    end

    // Zero divisor with start held: stall only at t, ready at t+1, restart at t+2.
    applyStimulus(1'b0, 32'd9, 32'd0);
    checkOutput("zheld_t_stall", {31'd0, stallreq_for_ex}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("zheld_t1_ready", {31'd0, div_ready}, 32'd1);
    checkOutput("zheld_t1_stall", {31'd0, stallreq_for_ex}, 32'd0);
    checkOutput("zheld_t1_lo", div_lo, 32'd0);
    checkOutput("zheld_t1_hi", div_hi, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("zheld_t2_stall", {31'd0, stallreq_for_ex}, 32'd1);
    checkOutput("zheld_t2_ready", {31'd0, div_ready}, 32'd0);
    div_start = 1'b0;
    repeat (2) @(negedge clk);

    // Held start on a nonzero divide returns through IDLE at t+34.
    applyStimulus(1'b0, 32'd100, 32'd7);
    waitResult(lat, stalls, hi, lo);
    checkOutput("held_lat", lat, 32'd33);
    @(negedge clk);
    #1;
    checkOutput("held_t34_ready", {31'd0, div_ready}, 32'd0);
    checkOutput("held_t34_stall", {31'd0, stallreq_for_ex}, 32'd1);
    div_start = 1'b0;
    @(negedge clk);

    // Operands changed during BUSY must not affect the result.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    dividend = 32'd999;
    divisor  = 32'd0;
    waitResult(lat, stalls, hi, lo);
    div_start = 1'b0;
    checkOutput("chg_lat", lat + 3, 32'd33);
    checkOutput("chg_lo", lo, 32'h0000000E);
    checkOutput("chg_hi", hi, 32'h00000002);
    @(negedge clk);

    // annul at t+10: no ready, IDLE with zero outputs at t+11, new op at t+12.
    applyStimulus(1'b0, 32'd1000, 32'd3);
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (div_ready) cnt++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul     = 1'b0;
    div_start = 1'b0;
    #1;
    if (div_ready) cnt++;
    checkOutput("annul_noready", cnt, 32'd0);
    checkOutput("annul_t11_stall", {31'd0, stallreq_for_ex}, 32'd0);
    checkOutput("annul_t11_lo", div_lo, 32'd0);
    checkOutput("annul_t11_hi", div_hi, 32'd0);
    applyStimulus(1'b0, 32'd50, 32'd5);
    waitResult(lat, stalls, hi, lo);
    div_start = 1'b0;
    checkOutput("annul_new_lat", lat, 32'd33);
    checkOutput("annul_new_lo", lo, 32'd10);
    checkOutput("annul_new_hi", hi, 32'd0);
    @(negedge clk);

    // rst at t+5 mid-BUSY: IDLE with zero outputs, then a clean divide.
    applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    div_start = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, div_ready}, 32'd0);
    checkOutput("rst_stall", {31'd0, stallreq_for_ex}, 32'd0);
    checkOutput("rst_lo", div_lo, 32'd0);
    checkOutput("rst_hi", div_hi, 32'd0);
    applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7);
    waitResult(lat, stalls, hi, lo);
    div_start = 1'b0;
    checkOutput("rst_new_lat", lat, 32'd33);
    checkOutput("rst_new_lo", lo, 32'hFFFFFFF2);
    checkOutput("rst_new_hi", hi, 32'hFFFFFFFE);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
